// File: rtl/cci_mpf_svc_vtp_tlb_assoc.sv
// cci_mpf_svc_vtp_tlb_assoc: N-port set-associative VTP TLB with page-walker fill path and invalidate sweep.
// Hit/miss statistics counters are built only when VTP_TLB_STATS_EN is defined.
module cci_mpf_svc_vtp_tlb_assoc #(
   parameter int NUM_PORTS = 2,
   parameter int NUM_WAYS = 4,
   parameter int NUM_SETS = 64,
   parameter int VA_IDX_BITS = 36,
   parameter int PA_IDX_BITS = 26,
   parameter int BIG_PAGE = 0
) (
   input  logic clk,
   input  logic reset_n,
   input  logic [NUM_PORTS-1:0] lookup_en,
   input  logic [NUM_PORTS*VA_IDX_BITS-1:0] lookup_va,
   output logic lookup_rdy,
   output logic [NUM_PORTS-1:0] rsp_valid,
   output logic [NUM_PORTS-1:0] rsp_hit,
   output logic [NUM_PORTS*PA_IDX_BITS-1:0] rsp_pa,
   output logic [NUM_PORTS-1:0] rsp_big_page,
   output logic [NUM_PORTS-1:0] miss_en,
   output logic [NUM_PORTS*VA_IDX_BITS-1:0] miss_va,
   input  logic fill_en,
   input  logic [VA_IDX_BITS-1:0] fill_va,
   input  logic [PA_IDX_BITS-1:0] fill_pa,
   output logic fill_rdy,
   input  logic inval_en,
   output logic [31:0] hit_count,
   output logic [31:0] miss_count
);
   localparam int OFS = BIG_PAGE ? 9 : 0;
   localparam int SET_W = $clog2(NUM_SETS);
   localparam int TAG_W = VA_IDX_BITS - OFS - SET_W;
   localparam int SPA_W = PA_IDX_BITS - OFS;
   localparam int WAY_W = NUM_WAYS > 1 ? $clog2(NUM_WAYS) : 1;

   function automatic logic [SET_W-1:0] set_of(input logic [VA_IDX_BITS-1:0] va);
      return va[OFS +: SET_W];
   endfunction

   function automatic logic [TAG_W-1:0] tag_of(input logic [VA_IDX_BITS-1:0] va);
      return va[VA_IDX_BITS-1 -: TAG_W];
   endfunction

   typedef enum logic [1:0] {INIT, RUN, FILL_RD, FILL_WR} state_t;

   logic [NUM_WAYS-1:0] valid [NUM_SETS];
   logic [TAG_W-1:0] tags [NUM_SETS][NUM_WAYS];
   logic [SPA_W-1:0] pas [NUM_SETS][NUM_WAYS];
   state_t state, state_nxt;
   logic [SET_W-1:0] init_idx;
   logic [VA_IDX_BITS-1:0] f_va;
   logic [SPA_W-1:0] f_pa;
   logic [NUM_WAYS-1:0] f_valid;
   logic [TAG_W-1:0] f_tags [NUM_WAYS];
   logic [WAY_W-1:0] victim, f_way;
   logic f_use_victim;

   assign lookup_rdy = state != INIT;
   assign fill_rdy = state == RUN;

   always_comb begin
      state_nxt = state;
      if (inval_en) state_nxt = INIT;
      else
         case (state)
            INIT: if (&init_idx) state_nxt = RUN;
            RUN: if (fill_en) state_nxt = FILL_RD;
            FILL_RD: state_nxt = FILL_WR;
            default: state_nxt = RUN;
         endcase
   end

   // Tag match beats a free way, which beats the round-robin victim; lowest way wins each tier.
   always_comb begin
      f_way = victim;
      f_use_victim = 1'b1;
      for (int w = NUM_WAYS-1; w >= 0; w--)
         if (!f_valid[w]) begin
            f_way = WAY_W'(w);
            f_use_victim = 1'b0;
         end
      for (int w = NUM_WAYS-1; w >= 0; w--)
         if (f_valid[w] && f_tags[w] == tag_of(f_va)) begin
            f_way = WAY_W'(w);
            f_use_victim = 1'b0;
         end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= INIT;
         init_idx <= '0;
         victim <= '0;
      end else begin
         state <= state_nxt;
         init_idx <= (state == INIT && !inval_en) ? init_idx + 1'b1 : '0;
         if (state == FILL_WR && !inval_en && f_use_victim)
            victim <= (victim == WAY_W'(NUM_WAYS-1)) ? '0 : victim + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (state == RUN && fill_en) begin
         f_va <= fill_va;
         f_pa <= fill_pa[PA_IDX_BITS-1 -: SPA_W];
      end
      if (state == FILL_RD) begin
         f_valid <= valid[set_of(f_va)];
         f_tags <= tags[set_of(f_va)];
      end
      if (state == INIT) valid[init_idx] <= '0;
      else if (state == FILL_WR && !inval_en) begin
         valid[set_of(f_va)][f_way] <= 1'b1;
         tags[set_of(f_va)][f_way] <= tag_of(f_va);
         pas[set_of(f_va)][f_way] <= f_pa;
      end
   end

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
      logic [VA_IDX_BITS-1:0] va, s1_va, r_va;
      logic s1_v, r_v, r_hit, hit;
      logic [NUM_WAYS-1:0] s1_valid;
      logic [TAG_W-1:0] s1_tags [NUM_WAYS];
      logic [SPA_W-1:0] s1_pas [NUM_WAYS];
      logic [SPA_W-1:0] pa;
      logic [PA_IDX_BITS-1:0] pa_full, r_pa;
      assign va = lookup_va[p*VA_IDX_BITS +: VA_IDX_BITS];
      always_comb begin
         hit = 1'b0;
         pa = '0;
         for (int w = NUM_WAYS-1; w >= 0; w--)
            if (s1_valid[w] && s1_tags[w] == tag_of(s1_va)) begin
               hit = 1'b1;
               pa = s1_pas[w];
            end
      end
      if (BIG_PAGE != 0) begin : g_big
         assign pa_full = {pa, s1_va[8:0]};
      end else begin : g_small
         assign pa_full = pa;
      end
      // Set contents are captured at issue, so in-flight lookups ignore later fills and invalidates.
      always_ff @(posedge clk) begin
         s1_va <= va;
         s1_valid <= valid[set_of(va)];
         s1_tags <= tags[set_of(va)];
         s1_pas <= pas[set_of(va)];
      end
      always_ff @(posedge clk) begin
         if (!reset_n) begin
            s1_v <= 1'b0;
            r_v <= 1'b0;
            r_hit <= 1'b0;
            r_pa <= '0;
            r_va <= '0;
         end else begin
            s1_v <= lookup_en[p] && lookup_rdy;
            r_v <= s1_v;
            r_hit <= s1_v && hit;
            r_pa <= (s1_v && hit) ? pa_full : '0;
            if (s1_v) r_va <= s1_va;
         end
      end
      assign rsp_valid[p] = r_v;
      assign rsp_hit[p] = r_hit;
      assign rsp_pa[p*PA_IDX_BITS +: PA_IDX_BITS] = r_pa;
      assign rsp_big_page[p] = r_hit && BIG_PAGE != 0;
      assign miss_en[p] = r_v && !r_hit;
      assign miss_va[p*VA_IDX_BITS +: VA_IDX_BITS] = r_va;
   end

`ifdef VTP_TLB_STATS_EN
   logic [32:0] hit_sum, miss_sum;
   assign hit_sum = {1'b0, hit_count} + 33'($countones(rsp_valid & rsp_hit));
   assign miss_sum = {1'b0, miss_count} + 33'($countones(miss_en));
   always_ff @(posedge clk) begin
      if (!reset_n || inval_en) begin
         hit_count <= '0;
         miss_count <= '0;
      end else begin
         hit_count <= hit_sum[32] ? '1 : hit_sum[31:0];
         miss_count <= miss_sum[32] ? '1 : miss_sum[31:0];
      end
   end
`else
   assign hit_count = '0;
   assign miss_count = '0;
`endif
endmodule

// File: tb/tb_cci_mpf_svc_vtp_tlb_assoc.sv
// tb_cci_mpf_svc_vtp_tlb_assoc: scoreboard bench; instance a uses 4KB pages, instance b uses 2MB pages.
module tb_cci_mpf_svc_vtp_tlb_assoc;
   localparam int VA_W = 36;
   localparam int PA_W = 26;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [1:0] a_lookup_en = '0, b_lookup_en = '0;
   logic [2*VA_W-1:0] a_lookup_va = '0, b_lookup_va = '0;
   logic a_lookup_rdy, b_lookup_rdy, a_fill_rdy, b_fill_rdy;
   logic [1:0] a_rsp_valid, a_rsp_hit, a_rsp_big_page, a_miss_en;
   logic [1:0] b_rsp_valid, b_rsp_hit, b_rsp_big_page, b_miss_en;
   logic [2*PA_W-1:0] a_rsp_pa, b_rsp_pa;
   logic [2*VA_W-1:0] a_miss_va, b_miss_va;
   logic a_fill_en = 1'b0, b_fill_en = 1'b0, a_inval_en = 1'b0, b_inval_en = 1'b0;
   logic [VA_W-1:0] a_fill_va = '0, b_fill_va = '0;
   logic [PA_W-1:0] a_fill_pa = '0, b_fill_pa = '0;
   logic [31:0] a_hit_count, a_miss_count, b_hit_count, b_miss_count;
   logic b_done = 1'b0;

   cci_mpf_svc_vtp_tlb_assoc #(.BIG_PAGE(0)) dut_a (
      .clk(clk), .reset_n(reset_n), .lookup_en(a_lookup_en), .lookup_va(a_lookup_va),
      .lookup_rdy(a_lookup_rdy), .rsp_valid(a_rsp_valid), .rsp_hit(a_rsp_hit), .rsp_pa(a_rsp_pa),
      .rsp_big_page(a_rsp_big_page), .miss_en(a_miss_en), .miss_va(a_miss_va), .fill_en(a_fill_en),
      .fill_va(a_fill_va), .fill_pa(a_fill_pa), .fill_rdy(a_fill_rdy), .inval_en(a_inval_en),
      .hit_count(a_hit_count), .miss_count(a_miss_count));

   cci_mpf_svc_vtp_tlb_assoc #(.BIG_PAGE(1)) dut_b (
      .clk(clk), .reset_n(reset_n), .lookup_en(b_lookup_en), .lookup_va(b_lookup_va),
      .lookup_rdy(b_lookup_rdy), .rsp_valid(b_rsp_valid), .rsp_hit(b_rsp_hit), .rsp_pa(b_rsp_pa),
      .rsp_big_page(b_rsp_big_page), .miss_en(b_miss_en), .miss_va(b_miss_va), .fill_en(b_fill_en),
      .fill_va(b_fill_va), .fill_pa(b_fill_pa), .fill_rdy(b_fill_rdy), .inval_en(b_inval_en),
      .hit_count(b_hit_count), .miss_count(b_miss_count));

   typedef struct {
      int due;
      logic hit;
      logic [PA_W-1:0] pa;
      logic [VA_W-1:0] va;
      logic big;
   } exp_t;

   // Scoreboard index: 0,1 = dut_a ports; 2,3 = dut_b ports.
   exp_t q [4][$];
   exp_t mon_e;
   logic [3:0] rv, rh, rb, me;
   logic [PA_W-1:0] rpa [4];
   logic [VA_W-1:0] mva [4];
   int n_chk = 0;
   int n_fail = 0;

   always_comb begin
      rv = {b_rsp_valid, a_rsp_valid};
      rh = {b_rsp_hit, a_rsp_hit};
      rb = {b_rsp_big_page, a_rsp_big_page};
      me = {b_miss_en, a_miss_en};
      for (int i = 0; i < 2; i++) begin
         rpa[i] = a_rsp_pa[i*PA_W +: PA_W];
         rpa[i+2] = b_rsp_pa[i*PA_W +: PA_W];
         mva[i] = a_miss_va[i*VA_W +: VA_W];
         mva[i+2] = b_miss_va[i*VA_W +: VA_W];
      end
   end

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   always @(negedge clk) begin
      if (reset_n) begin
         for (int i = 0; i < 4; i++) begin
            if (q[i].size() != 0 && q[i][0].due == cyc) begin
               mon_e = q[i].pop_front();
               chk($sformatf("rsp_valid_s%0d", i), 64'(rv[i]), 64'(1));
               if (rv[i]) begin
                  chk($sformatf("rsp_hit_s%0d", i), 64'(rh[i]), 64'(mon_e.hit));
                  chk($sformatf("rsp_pa_s%0d", i), 64'(rpa[i]), 64'(mon_e.pa));
                  chk($sformatf("miss_en_s%0d", i), 64'(me[i]), 64'(!mon_e.hit));
                  chk($sformatf("rsp_big_page_s%0d", i), 64'(rb[i]), 64'(mon_e.big));
                  if (!mon_e.hit) chk($sformatf("miss_va_s%0d", i), 64'(mva[i]), 64'(mon_e.va));
               end
            end else if (rv[i]) chk($sformatf("unexpected_rsp_s%0d", i), 64'(rv[i]), 64'(0));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic step(input int d);
      tick();
      if (d == 0) a_lookup_en = '0;
      else b_lookup_en = '0;
   endtask

   task automatic req(input int d, input int p, input logic [VA_W-1:0] va, input logic h,
                      input logic [PA_W-1:0] pa_e, input logic push);
      exp_t e;
      if (d == 0) begin
         a_lookup_en[p] = 1'b1;
         a_lookup_va[p*VA_W +: VA_W] = va;
      end else begin
         b_lookup_en[p] = 1'b1;
         b_lookup_va[p*VA_W +: VA_W] = va;
      end
      e = '{due: cyc + 2, hit: h, pa: h ? pa_e : '0, va: va, big: h && d == 1};
      if (push) q[d*2+p].push_back(e);
   endtask

   // Returns three cycles after issue, the first cycle a lookup sees the new entry.
   task automatic fill(input int d, input logic [VA_W-1:0] va, input logic [PA_W-1:0] pa);
      chk($sformatf("fill_rdy_d%0d", d), 64'(d ? b_fill_rdy : a_fill_rdy), 64'(1));
      if (d == 0) begin
         a_fill_en = 1'b1;
         a_fill_va = va;
         a_fill_pa = pa;
      end else begin
         b_fill_en = 1'b1;
         b_fill_va = va;
         b_fill_pa = pa;
      end
      tick();
      if (d == 0) a_fill_en = 1'b0;
      else b_fill_en = 1'b0;
      tick();
      tick();
   endtask

   task automatic wait_rdy(input int d, output int n);
      n = 0;
      while ((d ? b_lookup_rdy : a_lookup_rdy) !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      wait (reset_n === 1'b1);
      tick();
      wait_rdy(1, n);
      chk("b_lookup_rdy_after_init", 64'(b_lookup_rdy), 64'(1));
      fill(1, 36'h40200, 26'h00400);
      req(1, 0, 36'h40355, 1'b1, 26'h00555, 1'b1);
      req(1, 1, 36'h40200, 1'b1, 26'h00400, 1'b1);
      step(1);
      req(1, 0, 36'h40555, 1'b0, '0, 1'b1);
      step(1);
      fill(1, 36'h80000, 26'h00BFF);
      req(1, 1, 36'h80001, 1'b1, 26'h00A01, 1'b1);
      step(1);
      b_done = 1'b1;
   end

   initial begin
      int n;
      repeat (3) tick();
      chk("rst_lookup_rdy", 64'(a_lookup_rdy), 64'(0));
      chk("rst_fill_rdy", 64'(a_fill_rdy), 64'(0));
      chk("rst_rsp_valid", 64'(a_rsp_valid), 64'(0));
      chk("rst_rsp_hit", 64'(a_rsp_hit), 64'(0));
      chk("rst_miss_en", 64'(a_miss_en), 64'(0));
      chk("rst_rsp_pa", 64'(a_rsp_pa), 64'(0));
      chk("rst_hit_count", 64'(a_hit_count), 64'(0));
      chk("rst_miss_count", 64'(a_miss_count), 64'(0));
      chk("rst_b_lookup_rdy", 64'(b_lookup_rdy), 64'(0));
      reset_n = 1'b1;
      req(0, 0, 36'h5, 1'b0, '0, 1'b0);
      step(0);
      wait_rdy(0, n);
      chk("init_cycles", 64'(n + 1), 64'(64));
      chk("fill_rdy_after_init", 64'(a_fill_rdy), 64'(1));
      req(0, 0, 36'h0, 1'b0, '0, 1'b1);
      step(0);
      fill(0, 36'h12345, 26'h0ABCD);
      req(0, 1, 36'h12345, 1'b1, 26'h0ABCD, 1'b1);
      step(0);
      // Lookups in FILL_RD and FILL_WR see old contents; the next cycle sees the new entry.
      chk("fill_rdy_run", 64'(a_fill_rdy), 64'(1));
      a_fill_en = 1'b1;
      a_fill_va = 36'h22222;
      a_fill_pa = 26'h01111;
      tick();
      a_fill_en = 1'b0;
      chk("fill_rdy_busy", 64'(a_fill_rdy), 64'(0));
      req(0, 0, 36'h22222, 1'b0, '0, 1'b1);
      step(0);
      req(0, 1, 36'h22222, 1'b0, '0, 1'b1);
      step(0);
      req(0, 0, 36'h22222, 1'b1, 26'h01111, 1'b1);
      step(0);
      for (int i = 0; i < 5; i++) fill(0, 36'h1000 + 36'(i * 64), 26'h100 + 26'(i));
      req(0, 0, 36'h1000, 1'b0, '0, 1'b1);
      step(0);
      for (int i = 1; i < 5; i++) begin
         req(0, i % 2, 36'h1000 + 36'(i * 64), 1'b1, 26'h100 + 26'(i), 1'b1);
         step(0);
      end
      fill(0, 36'h1040, 26'h200);
      req(0, 0, 36'h1040, 1'b1, 26'h200, 1'b1);
      req(0, 1, 36'h1080, 1'b1, 26'h102, 1'b1);
      step(0);
      req(0, 0, 36'h10C0, 1'b1, 26'h103, 1'b1);
      req(0, 1, 36'h1100, 1'b1, 26'h104, 1'b1);
      step(0);
      // The overwrite did not consume the victim pointer, so way 1 (0x1040) goes next.
      fill(0, 36'h1140, 26'h300);
      req(0, 0, 36'h1140, 1'b1, 26'h300, 1'b1);
      req(0, 1, 36'h1040, 1'b0, '0, 1'b1);
      step(0);
      req(0, 0, 36'h1080, 1'b1, 26'h102, 1'b1);
      step(0);
      for (int i = 0; i < 10; i++) begin
         chk($sformatf("inval_lookup_rdy_%0d", i), 64'(a_lookup_rdy), 64'(i <= 4));
         req(0, 0, 36'h12345, 1'b1, 26'h0ABCD, i <= 4);
         req(0, 1, 36'h12345, 1'b1, 26'h0ABCD, i <= 4);
         a_inval_en = (i == 4);
         step(0);
      end
      a_inval_en = 1'b0;
      wait_rdy(0, n);
      chk("inval_init_cycles", 64'(n + 5), 64'(64));
`ifdef VTP_TLB_STATS_EN
      chk("hit_count_post_inval", 64'(a_hit_count), 64'(4));
`else
      chk("hit_count_post_inval", 64'(a_hit_count), 64'(0));
`endif
      chk("miss_count_post_inval", 64'(a_miss_count), 64'(0));
      a_inval_en = 1'b1;
      tick();
      a_inval_en = 1'b0;
      wait_rdy(0, n);
      chk("inval2_init_cycles", 64'(n), 64'(64));
      chk("hit_count_cleared", 64'(a_hit_count), 64'(0));
      req(0, 0, 36'h12345, 1'b0, '0, 1'b1);
      step(0);
      fill(0, 36'h12345, 26'h0ABCD);
      for (int i = 0; i < 3; i++) begin
         req(0, 0, 36'h12345, 1'b1, 26'h0ABCD, 1'b1);
         req(0, 1, 36'h12345, 1'b1, 26'h0ABCD, 1'b1);
         step(0);
      end
      repeat (4) tick();
`ifdef VTP_TLB_STATS_EN
      chk("hit_count", 64'(a_hit_count), 64'(6));
      chk("miss_count", 64'(a_miss_count), 64'(1));
`else
      chk("hit_count", 64'(a_hit_count), 64'(0));
      chk("miss_count", 64'(a_miss_count), 64'(0));
`endif
      for (int k = 0; k < 500 && !b_done; k++) tick();
      chk("b_sequence_done", 64'(b_done), 64'(1));
      repeat (4) tick();
      for (int i = 0; i < 4; i++) chk($sformatf("missing_rsp_s%0d", i), 64'(q[i].size()), 64'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
